// File: rtl/toggle_rx_pkg.sv
// Shared constants and types for the toggle-coded frame receiver.
// Optional de-stuffing is selected with the TOGGLE_RX_DESTUFF_EN macro.
package toggle_rx_pkg;
    localparam logic [7:0] FLAG      = 8'h7E;
    localparam int         STUFF_RUN = 5;
    localparam int         ABORT_RUN = 7;

    typedef enum logic {HUNT, DATA} rx_state_e;

    typedef struct packed {
        logic sof;
        logic eof;
        logic err;
    } frame_evt_t;
endpackage

// File: rtl/toggle_bit_decoder.sv
// Recovers data bits from the toggle-coded line: a change of level is a 1.
module toggle_bit_decoder (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    input  logic bit_en,
    output logic d,
    output logic d_stb
);
    logic prev_line;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            prev_line <= 1'b0;
        else if (bit_en)
            prev_line <= line;
    end

    assign d     = line ^ prev_line;
    assign d_stb = bit_en;
endmodule

// File: rtl/toggle_frame_rx.sv
// Toggle-coded serial receiver: flag hunt, LSB-first byte assembly, valid/ready output.
// Define TOGGLE_RX_DESTUFF_EN for zero-bit de-stuffing and abort detection in DATA.
module toggle_frame_rx
    import toggle_rx_pkg::*;
#(
    parameter int MAX_FRAME = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line,
    input  logic       bit_en,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       sof,
    output logic       eof,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(MAX_FRAME + 1);

    logic d, d_stb;

    toggle_bit_decoder u_dec (
        .clk    (clk),
        .reset_n(reset_n),
        .line   (line),
        .bit_en (bit_en),
        .d      (d),
        .d_stb  (d_stb)
    );

    rx_state_e     state, state_n;
    // Only the older 7 bits of the flag window are stored; the 8th is the live bit.
    logic [6:0]    flag_sr, flag_sr_n;
    logic [6:0]    acc, acc_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [CW-1:0] byte_cnt, byte_cnt_n;
    logic          byte_seen, byte_seen_n;
    logic [7:0]    data_n;
    logic          valid_n, ovr_n;
    frame_evt_t    evt, evt_n;
    logic          flag_hit, wrap;
`ifdef TOGGLE_RX_DESTUFF_EN
    logic [2:0]    run, run_n;
`endif

    assign flag_hit = ({d, flag_sr} == FLAG);
    assign wrap     = (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HUNT;
            flag_sr    <= '0;
            acc        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            byte_seen  <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            evt        <= '0;
`ifdef TOGGLE_RX_DESTUFF_EN
            run        <= '0;
`endif
        end else begin
            state      <= state_n;
            flag_sr    <= flag_sr_n;
            acc        <= acc_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            byte_seen  <= byte_seen_n;
            data       <= data_n;
            data_valid <= valid_n;
            overrun    <= ovr_n;
            evt        <= evt_n;
`ifdef TOGGLE_RX_DESTUFF_EN
            run        <= run_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        flag_sr_n   = flag_sr;
        acc_n       = acc;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        byte_seen_n = byte_seen;
        data_n      = data;
        valid_n     = data_valid && !data_ready;
        ovr_n       = overrun;
        evt_n       = '0;
`ifdef TOGGLE_RX_DESTUFF_EN
        run_n       = run;
`endif
        if (d_stb) begin
            flag_sr_n = {d, flag_sr[6:1]};
            case (state)
                HUNT: begin
                    if (flag_hit) begin
                        state_n     = DATA;
                        evt_n.sof   = 1'b1;
                        bit_cnt_n   = '0;
                        byte_cnt_n  = '0;
                        byte_seen_n = 1'b0;
                        ovr_n       = 1'b0;
`ifdef TOGGLE_RX_DESTUFF_EN
                        run_n       = '0;
`endif
                    end
                end
                DATA: begin
                    if (flag_hit) begin
                        // Flags before the first byte are idle fill; realign on them.
                        if (!byte_seen) begin
                            bit_cnt_n = '0;
                        end else if (wrap) begin
                            evt_n.eof = 1'b1;
                            state_n   = HUNT;
                        end else begin
                            evt_n.err = 1'b1;
                            state_n   = HUNT;
                        end
`ifdef TOGGLE_RX_DESTUFF_EN
                        run_n = '0;
                    end else if (d && run == 3'(ABORT_RUN - 1)) begin
                        evt_n.err = 1'b1;
                        state_n   = HUNT;
                    end else if (!d && run == 3'(STUFF_RUN)) begin
                        run_n = '0;
`endif
                    end else begin
                        acc_n     = {d, acc[6:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
`ifdef TOGGLE_RX_DESTUFF_EN
                        run_n     = d ? run + 3'd1 : 3'd0;
`endif
                        if (wrap) begin
                            if (byte_cnt == CW'(MAX_FRAME)) begin
                                evt_n.err = 1'b1;
                                state_n   = HUNT;
                            end else begin
                                byte_cnt_n  = byte_cnt + 1'b1;
                                byte_seen_n = 1'b1;
                                if (data_valid && !data_ready) begin
                                    ovr_n = 1'b1;
                                end else begin
                                    data_n  = {d, acc};
                                    valid_n = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign sof       = evt.sof;
    assign eof       = evt.eof;
    assign frame_err = evt.err;
endmodule

// File: tb/tb_toggle_frame_rx.sv
// Directed bench for toggle_frame_rx (MAX_FRAME=2); destuff checks need TOGGLE_RX_DESTUFF_EN.
module tb_toggle_frame_rx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       line = 1'b0;
    logic       bit_en = 1'b0;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid, sof, eof, frame_err, overrun;

    logic       tline = 1'b0;
    int         tests = 0;
    int         fails = 0;
    int         n_sof = 0, n_eof = 0, n_err = 0;
    logic [7:0] rxq[$];

    toggle_frame_rx #(.MAX_FRAME(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line      (line),
        .bit_en    (bit_en),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .sof       (sof),
        .eof       (eof),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pre-edge values: accepted bytes and event pulses.
    always @(posedge clk) begin
        if (data_valid && data_ready) rxq.push_back(data);
        if (sof) n_sof++;
        if (eof) n_eof++;
        if (frame_err) n_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        tline  = tline ^ b;
        line   = tline;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 0, 7);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bit_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_sof = 0; n_eof = 0; n_err = 0;
        rxq.delete();
    endtask

    initial begin
        // Reset held with the line toggling
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        chk("reset_outs", {data, data_valid, sof, eof, frame_err, overrun}, 0);
        idle(1);
        chk("reset_no_sof", n_sof, 0);
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(2);
        chk("no_sof_wo_flag", n_sof, 0);

        // Basic frame
        clr();
        send_byte(8'h7E);
        chk("basic_sof", sof, 1);
        send_byte(8'hA5);
        chk("basic_v1", {data_valid, data}, {1'b1, 8'hA5});
        send_bits(8'h3C, 0, 0);
        chk("basic_vfall", data_valid, 0);
        send_bits(8'h3C, 1, 7);
        chk("basic_v2", {data_valid, data}, {1'b1, 8'h3C});
        send_byte(8'h7E);
        chk("basic_eof", eof, 1);
        idle(3);
        chk("basic_nbytes", rxq.size(), 2);
        chk("basic_b0", rxq[0], 8'hA5);
        chk("basic_b1", rxq[1], 8'h3C);
        chk("basic_cnts", {n_sof[7:0], n_eof[7:0], n_err[7:0]}, 24'h010100);

        // Backpressure
        clr();
        data_ready = 1'b0;
        send_byte(8'h7E);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("bp_hold", {data_valid, data, overrun}, {1'b1, 8'h11, 1'b1});
        send_byte(8'h7E);
        chk("bp_eof", eof, 1);
        chk("bp_sticky", overrun, 1);
        @(negedge clk);
        data_ready = 1'b1;
        idle(2);
        chk("bp_nbytes", rxq.size(), 1);
        chk("bp_b0", rxq[0], 8'h11);

        // Idle flags
        clr();
        send_byte(8'h7E);
        chk("ovr_clr_sof", {sof, overrun}, 2'b10);
        send_byte(8'h7E);
        send_byte(8'h7E);
        send_byte(8'h11);
        send_byte(8'h7E);
        idle(3);
        chk("idle_cnts", {n_sof[7:0], n_eof[7:0], n_err[7:0]}, 24'h010100);
        chk("idle_nbytes", rxq.size(), 1);
        chk("idle_b0", rxq[0], 8'h11);

        // Misaligned closing flag
        clr();
        send_byte(8'h7E);
        send_byte(8'h55);
        send_bits(8'h05, 0, 2);
        send_byte(8'h7E);
        chk("mis_err", {frame_err, eof}, 2'b10);
        send_byte(8'h11);
        idle(3);
        chk("mis_nbytes", rxq.size(), 2);
        chk("mis_b1", rxq[1], 8'hF5);
        chk("mis_hunt", {n_sof[7:0], n_eof[7:0], n_err[7:0]}, 24'h010001);

        // Length limit
        clr();
        send_byte(8'h7E);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        chk("len_err", frame_err, 1);
        idle(3);
        chk("len_nbytes", rxq.size(), 2);
        chk("len_b1", rxq[1], 8'hBB);
        chk("len_cnts", {n_eof[7:0], n_err[7:0]}, 16'h0001);

        // Reset mid-frame
        clr();
        data_ready = 1'b0;
        send_byte(8'h7E);
        send_byte(8'h33);
        send_bits(8'h44, 0, 2);
        @(negedge clk);
        bit_en  = 1'b0;
        reset_n = 1'b0;
        tline   = 1'b0;
        line    = 1'b0;
        #1;
        chk("rst_mid_outs", {data, data_valid, sof, eof, frame_err, overrun}, 0);
        idle(3);
        chk("rst_mid_evts", {n_eof[7:0], n_err[7:0]}, 16'h0000);
        @(negedge clk);
        reset_n    = 1'b1;
        data_ready = 1'b1;

`ifdef TOGGLE_RX_DESTUFF_EN
        clr();
        send_byte(8'h7E);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        chk("ds_data", {data_valid, data}, {1'b1, 8'h1F});
        send_byte(8'h7E);
        chk("ds_eof", eof, 1);
        send_byte(8'h7E);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("ds_abort", frame_err, 1);
        idle(3);
        chk("ds_cnts", {n_sof[7:0], n_eof[7:0], n_err[7:0]}, 24'h020101);
`else
        clr();
        send_byte(8'h7E);
        send_byte(8'hFF);
        chk("nods_ff", {data_valid, data, frame_err}, {1'b1, 8'hFF, 1'b0});
        send_byte(8'h7E);
        chk("nods_eof", eof, 1);
        send_byte(8'h22);
        idle(3);
        chk("nods_nbytes", rxq.size(), 1);
        chk("nods_cnts", {n_sof[7:0], n_eof[7:0], n_err[7:0]}, 24'h010100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/toggle_frame_rx.md
# toggle_frame_rx

Receive side of the toggle-coded serial link. The transmit end drives the line from a T flip-flop: `t` is the data bit, so the line toggles for a 1 and holds for a 0. This block recovers the bits by XOR-ing each line sample with the previous one. It then finds 0x7E frame flags and assembles LSB-first bytes, which it hands downstream over a valid/ready handshake. It sits between the line sampler and the packet buffer.

## Interface
Parameters:
- MAX_FRAME, 256: maximum number of data bytes per frame.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- line  input  1  toggle-coded line, already synchronised to clk.
- bit_en  input  1  strobe: sample `line` this cycle.
- data  output  8  received byte.
- data_valid  output  1  `data` holds a byte.
- data_ready  input  1  downstream accepts the byte.
- sof  output  1  one-cycle pulse: frame opened.
- eof  output  1  one-cycle pulse: frame closed cleanly.
- frame_err  output  1  one-cycle pulse: frame discarded.
- overrun  output  1  sticky: a byte was dropped.

## Operation
- Reset:
  - all outputs are 0;
  - the stored previous line value is 0;
  - the state is HUNT;
  - all counters and shift registers are 0.
- Bit decode:
  - decoded bit `d = line ^ prev_line`;
  - `d` is used only on cycles where bit_en=1;
  - prev_line is updated only on those cycles;
  - cycles with bit_en=0 are ignored.
- Raw flag register: an 8-bit register, shifted right with `d` entering at bit 7, on every bit_en cycle in every state.
- HUNT state: when the raw flag register equals 0x7E, go to DATA and pulse sof.
  - bit_cnt is cleared;
  - byte_cnt is cleared;
  - the "byte seen" indicator is cleared;
  - overrun is cleared.
- DATA state: each accepted bit shifts into the byte accumulator LSB-first and increments bit_cnt (mod 8).
- Raw flag match in DATA:
  - The byte completing on that bit is suppressed.
  - If no byte has been delivered since sof, the flag is an idle/repeat flag: stay in DATA, no pulse.
  - Otherwise, if bit_cnt wraps to 0 on that bit, pulse eof and go to HUNT.
  - Otherwise (misaligned flag), pulse frame_err and go to HUNT.
- Byte completion (bit_cnt wraps to 0, no flag match): the byte goes into the output register, data_valid=1, byte_cnt increments.
  - If data_valid=1 and data_ready=0 on that cycle, the new byte is dropped, overrun=1, and the held byte is unchanged.
  - If data_valid=1 and data_ready=1 on that cycle, the held byte is consumed and the new byte loads; this is not an overrun.
- Frame length: a byte that would make byte_cnt exceed MAX_FRAME is not delivered; pulse frame_err and go to HUNT.
- Handshake: data_valid falls on the cycle after data_valid && data_ready, unless a new byte loads on that cycle.
- Going to HUNT does not cancel a byte already held in the output register.

## Timing
- data_valid rises on the cycle after the bit_en cycle that completes the byte.
- sof, eof and frame_err are registered and assert the cycle after the deciding bit_en cycle.
- At most one of sof, eof, frame_err pulses in any cycle.
- Throughput: one bit per clk when bit_en is held at 1.
- reset_n assertion mid-frame immediately forces every output and state element to its reset value; no eof or frame_err is generated.

## Configuration
- TOGGLE_RX_DESTUFF_EN defined: bit de-stuffing is active in DATA.
  - A run counter tracks consecutive decoded 1s.
  - A decoded 0 that follows exactly five 1s is discarded: it is not shifted in and bit_cnt does not advance.
  - Seven consecutive 1s is an abort: pulse frame_err, go to HUNT.
  - Flag detection still uses the raw (un-destuffed) register.
- TOGGLE_RX_DESTUFF_EN undefined: no de-stuffing and no abort detection. Every decoded bit is a data bit, so a 0x7E payload byte at a byte boundary closes the frame.

## Structure
- Package `toggle_rx_pkg`:
  - FLAG = 8'h7E;
  - STUFF_RUN = 5;
  - ABORT_RUN = 7;
  - state enum {HUNT, DATA}.
- Sub-module `toggle_bit_decoder`: holds the prev_line register and the XOR, and outputs `d` with a qualified strobe.

## Test plan
- Reset: with reset_n=0, line toggling and bit_en=1, all outputs stay 0. After release, no sof occurs until a 0x7E flag arrives.
- Basic frame: flag, bytes 0xA5 and 0x3C, flag, all with data_ready=1.
  - Expect sof, then data=0xA5 and data=0x3C, each valid one cycle after its 8th bit.
  - Expect eof one cycle after the final flag bit.
- Backpressure: data_ready=0 while two bytes arrive. Expect data=first byte held, second byte dropped, overrun=1. overrun clears at the next sof.
- Idle flags: three back-to-back 0x7E flags, then 0x11, then a flag. Expect one sof, one byte 0x11, one eof.
- Errors:
  - A closing flag after 3 data bits gives frame_err and return to HUNT.
  - With MAX_FRAME=2, a 3-byte frame gives exactly 2 bytes and then frame_err.
- Destuff (macro defined): payload 0x1F sent as five 1s, a stuffed 0, then 000. Expect data=0x1F. Seven 1s gives frame_err.
